// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a 16x4 single-port data memory.
//
// Each access takes three cycles: IDLE (request sampled), SERVE (memory access,
// write strobe asserted) and ACK (one-cycle completion pulse, read data valid).
// Ties go round-robin when RR=1, or to port 0 when RR=0.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   req0/1, we0/1              per-port request and write enable
//   addr0/1, wdata0/1          per-port word address and write data
//   ack0/1                     one-cycle completion pulse per port
//   rdata0/1                   per-port read data, held until that port's next ack
//   mem_we, mem_addr, mem_din  memory write strobe, address and write data
//   mem_dout                   combinational memory read data
//   gnt                        one-hot current owner (00 when idle)
module data_mem_arbiter #(
    parameter int unsigned RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       we0,
    input  logic [3:0] addr0,
    input  logic [3:0] wdata0,
    output logic       ack0,
    output logic [3:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [3:0] addr1,
    input  logic [3:0] wdata1,
    output logic       ack1,
    output logic [3:0] rdata1,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_din,
    input  logic [3:0] mem_dout,
    output logic [1:0] gnt
);

    typedef enum logic [1:0] {
        StIdle,
        StServe,
        StAck
    } state_e;

    state_e     state_q;
    logic       id_q;       // latched winner: 0 = port 0, 1 = port 1
    logic       last_q;     // most recently granted port
    logic       we_q;
    logic [3:0] addr_q;
    logic [3:0] wdata_q;
    logic [3:0] rdata0_q;
    logic [3:0] rdata1_q;
    logic       ack0_q;
    logic       ack1_q;
    logic [1:0] gnt_q;
    logic       win;

    // Winner among the current requests; only meaningful in IDLE.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = (RR != 0) ? ~last_q : 1'b0;
        end else begin
            win = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            id_q     <= 1'b0;
            last_q   <= 1'b1;  // port 0 wins the first tie
            we_q     <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 4'h0;
            rdata0_q <= 4'h0;
            rdata1_q <= 4'h0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            gnt_q    <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        state_q <= StServe;
                        id_q    <= win;
                        last_q  <= win;
                        we_q    <= win ? we1 : we0;
                        addr_q  <= win ? addr1 : addr0;
                        wdata_q <= win ? wdata1 : wdata0;
                        gnt_q   <= win ? 2'b10 : 2'b01;
                    end
                end
                StServe: begin
                    state_q <= StAck;
                    // Read captured at the write edge, so writes return old data.
                    if (id_q) begin
                        rdata1_q <= mem_dout;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q <= mem_dout;
                        ack0_q   <= 1'b1;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    gnt_q   <= 2'b00;
                end
                default: begin
                    state_q <= StIdle;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Gated by rst so a reset during SERVE cannot commit the write.
    assign mem_we   = (state_q == StServe) && we_q && !rst;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign gnt      = gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: one round-robin instance (a) and one
// fixed-priority instance (b) driven by the same request inputs, each with
// its own 16x4 memory model.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, wdata0, addr1, wdata1;

    logic       ack0_a, ack1_a, mem_we_a, ack0_b, ack1_b, mem_we_b;
    logic [3:0] rdata0_a, rdata1_a, mem_addr_a, mem_din_a, mem_dout_a;
    logic [3:0] rdata0_b, rdata1_b, mem_addr_b, mem_din_b, mem_dout_b;
    logic [1:0] gnt_a, gnt_b;

    logic [3:0] ram_a [16];
    logic [3:0] ram_b [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.RR(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0_a), .rdata0(rdata0_a),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1_a), .rdata1(rdata1_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a),
        .mem_dout(mem_dout_a), .gnt(gnt_a)
    );

    data_mem_arbiter #(.RR(0)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1_b), .rdata1(rdata1_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b),
        .mem_dout(mem_dout_b), .gnt(gnt_b)
    );

    // Initial image: ram[i] = i, except ram[1] = 3.
    function automatic logic [3:0] init_val(input int i);
        logic [3:0] v;
        v = 4'(i);
        if (i == 1) v = 4'd3;
        return v;
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                ram_a[i] <= init_val(i);
                ram_b[i] <= init_val(i);
            end
        end else begin
            if (mem_we_a) ram_a[mem_addr_a] <= mem_din_a;
            if (mem_we_b) ram_b[mem_addr_b] <= mem_din_b;
        end
    end

    assign mem_dout_a = ram_a[mem_addr_a];
    assign mem_dout_b = ram_b[mem_addr_b];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gnt_a"}, 8'(gnt_a), 8'h0);
        check({tag, " gnt_b"}, 8'(gnt_b), 8'h0);
        check({tag, " ack0_a"}, 8'(ack0_a), 8'h0);
        check({tag, " ack1_a"}, 8'(ack1_a), 8'h0);
        check({tag, " mem_we_a"}, 8'(mem_we_a), 8'h0);
        check({tag, " mem_addr_a"}, 8'(mem_addr_a), 8'h0);
        check({tag, " mem_din_a"}, 8'(mem_din_a), 8'h0);
        check({tag, " rdata0_a"}, 8'(rdata0_a), 8'h0);
        check({tag, " rdata1_a"}, 8'(rdata1_a), 8'h0);
    endtask

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rd;
    } txn_t;

    txn_t       tbl [8];
    logic [3:0] held0, held1;
    logic [1:0] exp_gnt;
    logic       seen;

    initial begin
        // Hand-computed: writes return the pre-write contents.
        tbl[0] = '{1'b0, 1'b0, 4'd1,  4'd0, 4'd3};
        tbl[1] = '{1'b1, 1'b1, 4'd5,  4'd9, 4'd5};
        tbl[2] = '{1'b0, 1'b0, 4'd5,  4'd0, 4'd9};
        tbl[3] = '{1'b1, 1'b0, 4'd1,  4'd0, 4'd3};
        tbl[4] = '{1'b0, 1'b1, 4'd15, 4'hA, 4'hF};
        tbl[5] = '{1'b1, 1'b0, 4'd15, 4'd0, 4'hA};
        tbl[6] = '{1'b0, 1'b1, 4'd0,  4'd6, 4'd0};
        tbl[7] = '{1'b1, 1'b0, 4'd0,  4'd0, 4'd6};

        rst = 1'b1; load = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 4'd0; wdata0 = 4'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; wdata1 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        held0 = 4'd0; held1 = 4'd0;

        // Single-port transactions from the table.
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (tbl[t].port) begin
                req1 = 1'b1; we1 = tbl[t].we; addr1 = tbl[t].addr; wdata1 = tbl[t].wdata;
            end else begin
                req0 = 1'b1; we0 = tbl[t].we; addr0 = tbl[t].addr; wdata0 = tbl[t].wdata;
            end
            exp_gnt = tbl[t].port ? 2'b10 : 2'b01;
            @(posedge clk); #1;  // SERVE
            check("txn serve gnt", 8'(gnt_a), 8'(exp_gnt));
            check("txn serve mem_we", 8'(mem_we_a), 8'(tbl[t].we));
            check("txn serve mem_addr", 8'(mem_addr_a), 8'(tbl[t].addr));
            if (tbl[t].we) check("txn serve mem_din", 8'(mem_din_a), 8'(tbl[t].wdata));
            check("txn serve acks", 8'({ack1_a, ack0_a}), 8'h0);
            @(posedge clk); #1;  // ACK
            if (tbl[t].port) held1 = tbl[t].exp_rd;
            else held0 = tbl[t].exp_rd;
            check("txn ack gnt", 8'(gnt_a), 8'(exp_gnt));
            check("txn ack acks", 8'({ack1_a, ack0_a}), 8'(exp_gnt));
            check("txn mem_we off", 8'(mem_we_a), 8'h0);
            check("txn rdata0", 8'(rdata0_a), 8'(held0));
            check("txn rdata1", 8'(rdata1_a), 8'(held1));
            req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
            @(posedge clk); #1;  // IDLE
            check("txn idle gnt", 8'(gnt_a), 8'h0);
            check("txn idle acks", 8'({ack1_a, ack0_a}), 8'h0);
        end
        check("ram5 written", 8'(ram_a[5]), 8'd9);
        check("ram15 written", 8'(ram_a[15]), 8'hA);

        // Address change after the grant edge must not affect the access.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        @(posedge clk); #1;
        addr0 = 4'd2;
        check("chg mem_addr", 8'(mem_addr_a), 8'd1);
        @(posedge clk); #1;
        check("chg ack0", 8'(ack0_a), 8'd1);
        check("chg rdata0", 8'(rdata0_a), 8'd3);
        req0 = 1'b0;
        @(posedge clk);

        // Reset during SERVE of a write: no write, no ack, outputs cleared.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 4'd7;
        @(posedge clk); #1;
        check("rstw serve gnt", 8'(gnt_a), 8'h1);
        rst = 1'b1; req0 = 1'b0;
        #1;
        check("rstw mem_we gated", 8'(mem_we_a), 8'h0);
        @(posedge clk); #1;
        check("rstw ram2", 8'(ram_a[2]), 8'd2);
        check_reset_outputs("rstw");
        @(negedge clk);
        rst = 1'b0; we0 = 1'b0;
        @(posedge clk); #1;
        check("rstw no ack0", 8'(ack0_a), 8'h0);

        // Both ports requesting continuously from reset.
        @(negedge clk);
        addr0 = 4'd1; addr1 = 4'd5;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            int ph;
            int slot;
            @(posedge clk); #1;
            ph = (c - 1) % 3;  // 0 SERVE, 1 ACK, 2 IDLE
            slot = (c - 1) / 3;
            exp_gnt = (ph == 2) ? 2'b00 : ((slot % 2) == 1 ? 2'b10 : 2'b01);
            check("tie rr gnt", 8'(gnt_a), 8'(exp_gnt));
            check("tie rr acks", 8'({ack1_a, ack0_a}), (ph == 1) ? 8'(exp_gnt) : 8'h0);
            if (ph == 1 && slot % 2 == 0) check("tie rr rdata0", 8'(rdata0_a), 8'd3);
            if (ph == 1 && slot % 2 == 1) check("tie rr rdata1", 8'(rdata1_a), 8'd9);
            check("tie fp gnt", 8'(gnt_b), (ph == 2) ? 8'h0 : 8'h1);
            check("tie fp ack0", 8'(ack0_b), (ph == 1) ? 8'h1 : 8'h0);
            check("tie fp ack1", 8'(ack1_b), 8'h0);
        end
        req0 = 1'b0;

        // Fixed priority: port 1 gets through once port 0 lets go.
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(posedge clk); #1;
            if (ack1_b) seen = 1'b1;
            check("fp no ack0 after drop", 8'(ack0_b), 8'h0);
        end
        check("fp port1 served", 8'(seen), 8'h1);
        req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("final gnt_a", 8'(gnt_a), 8'h0);
        check("final gnt_b", 8'(gnt_b), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  port 0 access request; held high until ack0.
REQ-005 we0  input  1  port 0 write enable (1=write, 0=read); valid while req0 is high.
REQ-006 addr0  input  4  port 0 word address.
REQ-007 wdata0  input  4  port 0 write data.
REQ-008 ack0  output  1  one-cycle completion pulse for port 0.
REQ-009 rdata0  output  4  port 0 read data; valid while ack0 is high and held until port 0's next ack.
REQ-010 req1, we1, addr1, wdata1, ack1, rdata1 SHALL be identical to REQ-004..REQ-009 for port 1.
REQ-011 mem_we  output  1  write enable to the 16x4 data memory.
REQ-012 mem_addr  output  4  address to the data memory.
REQ-013 mem_din  output  4  write data to the data memory.
REQ-014 mem_dout  input  4  combinational read data from the data memory.
REQ-015 gnt  output  2  one-hot current owner: 01 = port 0, 10 = port 1, 00 = none.

Function
REQ-016 The FSM SHALL have three states: IDLE, SERVE and ACK.
- IDLE->SERVE when req0 or req1 is sampled high; otherwise stay in IDLE.
- SERVE->ACK unconditionally.
- ACK->IDLE unconditionally.
REQ-017 On the IDLE->SERVE edge, the block SHALL latch the winner's id, we, addr and wdata into internal registers.
REQ-018 mem_addr and mem_din SHALL always drive the latched addr and wdata.
REQ-019 mem_we SHALL be 1 only when state is SERVE, the latched we is 1 and rst is 0.
REQ-020 On the SERVE->ACK edge, mem_dout SHALL be registered into the winner's rdata; the other port's rdata SHALL be unchanged.
REQ-021 ackN SHALL be 1 only in the ACK state and only for the winner; gnt SHALL be one-hot for the winner in SERVE and ACK, 00 in IDLE.
REQ-022 Latency: request sampled at edge N, memory access in cycle N+1, ack in cycle N+2; maximum throughput SHALL be one access per 3 cycles.
REQ-023 Requests SHALL NOT be sampled in SERVE or ACK; a requester SHALL deassert req, or present a new request, in the cycle after ack.
REQ-024 Single request in IDLE: that port SHALL win regardless of RR.
REQ-025 Simultaneous requests with RR=1: the winner SHALL be the port not granted most recently; the last-grant register SHALL update on every grant.
REQ-026 Simultaneous requests with RR=0: port 0 SHALL always win, and port 1 starvation is permitted.
REQ-027 A write SHALL return the pre-write memory contents on rdata, because the read is captured at the same edge as the write.
REQ-028 Changes on addr, wdata or we after the grant edge SHALL NOT affect the access in progress.

Reset
REQ-029 While rst=1, at the next edge: state=IDLE, ack0=ack1=0, gnt=00, mem_we=0, mem_addr=0, mem_din=0, rdata0=rdata1=0, last-grant=port 1 (so port 0 wins the first tie).
REQ-030 If rst is asserted during SERVE, no memory write SHALL occur at that edge (mem_we gated by REQ-019), no ack SHALL follow, and the request SHALL be discarded.

Verification
REQ-031 Read: memory preloaded ram[1]=3; req0=1, we0=0, addr0=1 at edge N -> mem_we=0 in cycle N+1, ack0=1 and rdata0=3 in cycle N+2, gnt=01 in N+1..N+2, ack1 stays 0.
REQ-032 Write then read: port 1 writes addr 5 with 9 -> mem_we=1 for exactly one cycle with mem_addr=5, mem_din=9; ack1 pulses; a following port 0 read of addr 5 -> rdata0=9.
REQ-033 Round-robin tie (RR=1): req0 and req1 held high continuously from reset -> grant order 0,1,0,1, acks every 3 cycles, never two consecutive grants to the same port.
REQ-034 Fixed priority (RR=0): req0 and req1 held high -> only ack0 pulses and ack1 never asserts; after req0 drops, port 1 is served within 3 cycles.
REQ-035 Reset mid-write: port 0 writes 7 to addr 2 (ram[2]=2) and rst=1 during SERVE -> ram[2] remains 2, no ack0, and all outputs are at reset values on the next cycle.
REQ-036 Input change: addr0 changes from 1 to 2 in the cycle after the grant -> rdata0 returns ram[1]=3, not ram[2].
